btn_conditioner: RTL and testbench



---
 rtl/calc_pkg.sv | 21 ++
 rtl/btn_debounce_ch.sv | 71 +++++++
 rtl/btn_conditioner.sv | 35 +++
 tb/tb_btn_conditioner.sv | 138 +++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the calculator front end: button bit map and the
// default debounce window.
package calc_pkg;

    localparam int BTN_U = 0;
    localparam int BTN_L = 1;
    localparam int BTN_C = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;
    localparam int N_BTN = 5;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES = 1_000_000;

    // Debounce channel states, implied by {level, cnt != 0}
    localparam logic [1:0] CH_IDLE_LOW  = 2'b00;
    localparam logic [1:0] CH_QUAL_HIGH = 2'b01;
    localparam logic [1:0] CH_IDLE_HIGH = 2'b10;
    localparam logic [1:0] CH_QUAL_LOW  = 2'b11;

endpackage

// File: rtl/btn_debounce_ch.sv
// Single push-button channel: 2-flop synchroniser, stability counter,
// debounced level and a one-cycle press pulse.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE_LOW   | level = 0, cnt = 0, synchronised input agrees with level
// QUAL_HIGH  | level = 0, cnt != 0, input has been high for cnt cycles
// IDLE_HIGH  | level = 1, cnt = 0, synchronised input agrees with level
// QUAL_LOW   | level = 1, cnt != 0, input has been low for cnt cycles
//
// The state is never stored explicitly; it is the pair (level, cnt != 0).
// Any cycle where the input agrees with level again drops a QUAL state
// back to its IDLE state, which is what rejects bounce.
module btn_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // The flip happens on the cycle the counter has seen a full window of
    // disagreement; cnt never passes CNT_LAST because the flip clears it.
    assign accept = (s2 != level) && (cnt == CNT_LAST);

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // Stability counter and debounced level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (s2 == level) begin
            cnt <= '0;
        end else if (accept) begin
            cnt   <= '0;
            level <= s2;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Press pulse lands in the same cycle level first reads 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse <= 1'b0;
        end else begin
            pulse <= accept && s2;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Board push-button conditioning for the calculator core: one independent
// debounce channel per button, clean levels plus press pulses.
module btn_conditioner #(
    parameter int N_BTN           = calc_pkg::N_BTN,
    parameter int DEBOUNCE_CYCLES = calc_pkg::DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // A zero-length window would make the counter compare meaningless
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

    // One identical channel per button bit
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_raw (btn_in[i]),
            .level   (btn_level[i]),
            .pulse   (btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a 4-cycle debounce window.
module tb_btn_conditioner;

    import calc_pkg::*;

    localparam int DB = 4;
    localparam int LAT = DB + 2;

    logic       clk;
    logic       rst_n;
    logic [4:0] btn_in;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;

    int n_tests;
    int n_fail;

    btn_conditioner #(
        .N_BTN           (5),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05b expected %05b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold current inputs for LAT-1 edges expecting the old level and no
    // pulse, then one more edge expecting the new level and pulse.
    task automatic qualify(input string tag, input logic [4:0] old_lvl,
                           input logic [4:0] new_lvl, input logic [4:0] exp_pulse);
        for (int k = 1; k < LAT; k++) begin
            step(1);
            chk({tag, "_wait_lvl"}, btn_level, old_lvl);
            chk({tag, "_wait_pls"}, btn_pulse, 5'b0);
        end
        step(1);
        chk({tag, "_lvl"}, btn_level, new_lvl);
        chk({tag, "_pls"}, btn_pulse, exp_pulse);
        step(1);
        chk({tag, "_pls_drop"}, btn_pulse, 5'b0);
        chk({tag, "_lvl_hold"}, btn_level, new_lvl);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        btn_in  = 5'h1F;

        // Reset with every button held
        #2;
        chk("rst_lvl_async", btn_level, 5'b0);
        chk("rst_pls_async", btn_pulse, 5'b0);
        step(3);
        chk("rst_lvl_held", btn_level, 5'b0);
        chk("rst_pls_held", btn_pulse, 5'b0);
        rst_n = 1'b1;
        qualify("rst_all", 5'h00, 5'h1F, 5'h1F);

        // Release everything: level falls LAT edges later, no pulse
        btn_in = 5'h00;
        qualify("rel_all", 5'h1F, 5'h00, 5'h00);

        // Clean press of btnd
        btn_in[BTN_D] = 1'b1;
        qualify("press_d", 5'h00, 5'h10, 5'h10);
        step(3);
        chk("press_d_held_pls", btn_pulse, 5'b0);
        chk("press_d_held_lvl", btn_level, 5'h10);
        btn_in[BTN_D] = 1'b0;
        qualify("rel_d", 5'h10, 5'h00, 5'h00);

        // Bounce on btnc: 1,0,1,0 then settle high
        for (int k = 0; k < 4; k++) begin
            btn_in[BTN_C] = (k % 2 == 0);
            step(1);
            chk("bounce_c_lvl", btn_level, 5'b0);
            chk("bounce_c_pls", btn_pulse, 5'b0);
        end
        btn_in[BTN_C] = 1'b1;
        qualify("bounce_c", 5'h00, 5'h04, 5'h04);
        btn_in[BTN_C] = 1'b0;
        qualify("rel_c", 5'h04, 5'h00, 5'h00);

        // Release of a held btnl
        btn_in[BTN_L] = 1'b1;
        qualify("press_l", 5'h00, 5'h02, 5'h02);
        btn_in[BTN_L] = 1'b0;
        qualify("rel_l", 5'h02, 5'h00, 5'h00);

        // Reset in the middle of qualifying btnr
        btn_in[BTN_R] = 1'b1;
        step(3);
        chk("midrst_pre_lvl", btn_level, 5'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_lvl", btn_level, 5'b0);
        chk("midrst_pls", btn_pulse, 5'b0);
        step(1);
        chk("midrst_lvl2", btn_level, 5'b0);
        chk("midrst_pls2", btn_pulse, 5'b0);
        rst_n = 1'b1;
        qualify("midrst_r", 5'h00, 5'h08, 5'h08);
        btn_in[BTN_R] = 1'b0;
        qualify("rel_r", 5'h08, 5'h00, 5'h00);

        // Simultaneous btnl, btnc, btnr
        btn_in = 5'b01110;
        qualify("simul", 5'h00, 5'b01110, 5'b01110);
        btn_in = 5'h00;
        qualify("rel_simul", 5'b01110, 5'h00, 5'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
